spike_mux_rr: RTL and testbench

Parametrised N-to-1 streaming multiplexer with a valid/ready handshake on every input and a registered output, used to merge spike/data streams from several neuron-grid sources onto one shared link. Arbitration is round-robin by default, and a forced-select mode gives static mux behaviour. Each output word carries the index of its source channel. It replaces single-cycle combinational muxing wherever sources can stall or contend.

---
 rtl/spike_mux_rr.sv | 106 ++++++++++
 tb/tb_spike_mux_rr.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_mux_rr.sv
// spike_mux_rr: N-to-1 valid/ready stream merger with a registered output.
// Round-robin arbitration by default; force_en turns it into a static mux on
// force_sel. Each output word is tagged with the index of its source channel.
module spike_mux_rr #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_sel,
    output logic                             out_valid,
    input  logic                             out_ready,
    input  logic                             force_en,
    input  logic [SEL_WIDTH-1:0]             force_sel
);

    // Pointer value that gives channel 0 first priority after reset.
    localparam logic [SEL_WIDTH-1:0] LAST_RESET = SEL_WIDTH'(NUM_INPUTS - 1);

    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_WIDTH-1:0]  last_grant_q, last_grant_d;

    logic                  load_en;
    logic [NUM_INPUTS-1:0] eligible;
    logic                  grant_found;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [SEL_WIDTH-1:0]  cand;
    logic [DATA_WIDTH-1:0] chan_data [NUM_INPUTS];

    // The output register can take a new word when empty or being drained.
    assign load_en = !out_valid_q || out_ready;

    // Per-channel eligibility, payload slicing and ready generation.
    // An out-of-range force_sel simply matches no channel.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
            assign eligible[gi]  = force_en ? (in_valid[gi] && (force_sel == SEL_WIDTH'(gi)))
                                            : in_valid[gi];
            assign chan_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_ready[gi]  = load_en && grant_found && (grant_idx == SEL_WIDTH'(gi));
        end
    endgenerate

    // Round-robin search: first eligible channel upward from last_grant+1.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            cand = SEL_WIDTH'((int'(last_grant_q) + 1 + i) % NUM_INPUTS);
            if (eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next-state for the output register and the arbitration pointer.
    always_comb begin
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            if (grant_found) begin
                out_data_d  = chan_data[grant_idx];
                out_sel_d   = grant_idx;
                out_valid_d = 1'b1;
                // Forced transfers must not disturb round-robin fairness.
                if (!force_en) begin
                    last_grant_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any held word immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_RESET;
        end else begin
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_spike_mux_rr.sv
// Bench for spike_mux_rr: a behavioural arbiter model checked every cycle on
// the 4-input instance, plus directed literal checks on both instances
// (a 3-input instance exercises an out-of-range force_sel).
module tb_spike_mux_rr;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ch_data [N];
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        force_en;
    logic [1:0]  force_sel;

    logic [23:0] s_in_data;
    logic [2:0]  s_in_valid;
    logic [2:0]  s_in_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_out_sel;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_force_en;
    logic [1:0]  s_force_sel;

    int n_checks = 0;
    int n_errors = 0;

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    always #5 clk = ~clk;

    spike_mux_rr #(.DATA_WIDTH(8), .NUM_INPUTS(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .force_en(force_en), .force_sel(force_sel)
    );

    spike_mux_rr #(.DATA_WIDTH(8), .NUM_INPUTS(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_sel(s_out_sel), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .force_en(s_force_en), .force_sel(s_force_sel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock; inputs change and literal checks happen 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel the arbitration rules select, or -1 if none.
    function automatic int model_grant(input int last, input logic [3:0] v,
                                       input logic fe, input logic [1:0] fs);
        if (fe) begin
            if (int'(fs) < N && v[fs]) return int'(fs);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Behavioural model + per-cycle comparison on the 4-input instance.
    logic       m_valid, nxt_valid;
    logic [7:0] m_data, nxt_data;
    logic [1:0] m_sel, nxt_sel;
    int         m_last, nxt_last;

    initial begin
        int         g;
        logic       load;
        logic [3:0] exp_ready;
        m_valid = 1'b0; m_data = '0; m_sel = '0; m_last = N - 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_valid = 1'b0; m_data = '0; m_sel = '0; m_last = N - 1;
            end
            load = !m_valid || out_ready;
            g = model_grant(m_last, in_valid, force_en, force_sel);
            exp_ready = '0;
            if (load && g >= 0) exp_ready[g[1:0]] = 1'b1;
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_sel", 32'(out_sel), 32'(m_sel));
            nxt_valid = m_valid; nxt_data = m_data; nxt_sel = m_sel; nxt_last = m_last;
            if (load && !rst) begin
                if (g >= 0) begin
                    nxt_valid = 1'b1;
                    nxt_data  = ch_data[g[1:0]];
                    nxt_sel   = g[1:0];
                    if (!force_en) nxt_last = g;
                    $display("xfer t=%0t ch=%0d data=%h forced=%0d", $time, g, ch_data[g[1:0]], force_en);
                end else begin
                    nxt_valid = 1'b0;
                end
            end
            @(posedge clk);
            if (!rst) begin
                m_valid = nxt_valid; m_data = nxt_data; m_sel = nxt_sel; m_last = nxt_last;
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b1;
        ch_data[0] = 8'h11; ch_data[1] = 8'h22; ch_data[2] = 8'h33; ch_data[3] = 8'h44;
        in_valid = 4'b1111; out_ready = 1'b1; force_en = 1'b0; force_sel = 2'd0;
        s_in_data = {8'hC3, 8'hB2, 8'hA1}; s_in_valid = 3'b000; s_out_ready = 1'b1;
        s_force_en = 1'b0; s_force_sel = 2'd0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'b0001);
        step(); step();
        rst = 1'b0;

        // Round-robin at full rate: 11,22,33,44,11
        step(); chk("rr0_data", 32'(out_data), 32'h11); chk("rr0_sel", 32'(out_sel), 32'd0);
        step(); chk("rr1_data", 32'(out_data), 32'h22); chk("rr1_sel", 32'(out_sel), 32'd1);
        step(); chk("rr2_data", 32'(out_data), 32'h33); chk("rr2_sel", 32'(out_sel), 32'd2);
        step(); chk("rr3_data", 32'(out_data), 32'h44); chk("rr3_sel", 32'(out_sel), 32'd3);
        step(); chk("rr4_data", 32'(out_data), 32'h11); chk("rr4_sel", 32'(out_sel), 32'd0);

        // Backpressure with 22 held
        step(); chk("bp_load_data", 32'(out_data), 32'h22);
        out_ready = 1'b0;
        #1 chk("bp_in_ready", 32'(in_ready), 32'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'h22);
            chk("bp_hold_sel", 32'(out_sel), 32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        step(); chk("bp_release_data", 32'(out_data), 32'h33); chk("bp_release_sel", 32'(out_sel), 32'd2);

        // Sparse: channels 3 and 1 only
        in_valid = 4'b1010;
        step(); chk("sp0_sel", 32'(out_sel), 32'd3);
        step(); chk("sp1_sel", 32'(out_sel), 32'd1); chk("sp1_data", 32'(out_data), 32'h22);
        step(); chk("sp2_sel", 32'(out_sel), 32'd3); chk("sp2_data", 32'(out_data), 32'h44);
        step(); chk("sp3_sel", 32'(out_sel), 32'd1);
        chk("sp_in_ready", 32'(in_ready), 32'b1000);

        // Forced mode on channel 2; last_grant is 1 going in
        in_valid = 4'b1111; force_en = 1'b1; force_sel = 2'd2;
        #1 chk("frc_in_ready", 32'(in_ready), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frc_sel", 32'(out_sel), 32'd2);
            chk("frc_data", 32'(out_data), 32'h33);
        end
        force_en = 1'b0;
        step(); chk("resume0_sel", 32'(out_sel), 32'd2);
        step(); chk("resume1_sel", 32'(out_sel), 32'd3);

        // Mid-stream reset with a held word
        out_ready = 1'b0;
        step(); chk("mr_held_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1 chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_data", 32'(out_data), 32'd0);
        step();
        rst = 1'b0; out_ready = 1'b1;
        step(); chk("mr_first_sel", 32'(out_sel), 32'd0); chk("mr_first_data", 32'(out_data), 32'h11);

        // 3-input instance: out-of-range force_sel
        s_in_valid = 3'b111;
        step(); chk("s_load_data", 32'(s_out_data), 32'hA1); chk("s_load_valid", 32'(s_out_valid), 32'd1);
        s_out_ready = 1'b0; s_force_en = 1'b1; s_force_sel = 2'd3;
        #1 chk("s_oor_in_ready_bp", 32'(s_in_ready), 32'd0);
        step(); chk("s_oor_held", 32'(s_out_valid), 32'd1);
        s_out_ready = 1'b1;
        #1 chk("s_oor_in_ready", 32'(s_in_ready), 32'd0);
        step();
        chk("s_oor_drop_valid", 32'(s_out_valid), 32'd0);
        chk("s_oor_keep_data", 32'(s_out_data), 32'hA1);
        chk("s_oor_keep_sel", 32'(s_out_sel), 32'd0);
        s_force_sel = 2'd2;
        step(); chk("s_frc_data", 32'(s_out_data), 32'hC3); chk("s_frc_sel", 32'(s_out_sel), 32'd2);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
